// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter: round-robin arbiter that keeps granting the same requester for up to
// MAX_BURST consumed grants (a "burst") before the pointer moves on. The burst lock is
// dropped early when the locked requester stops requesting.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   request      per-requester request, bit order per DIRECTION
//   update_lru   current grant is consumed this cycle
//   grant_oh     one-hot grant, bit order per DIRECTION, zero when nothing granted
//   grant_idx    logical index of the granted requester (0 when nothing granted)
//   grant_valid  any requester granted
module burst_rr_arbiter #(
   parameter int    NUM_REQUESTERS = 4,
   parameter string DIRECTION      = "LSB0",
   parameter int    MAX_BURST      = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQUESTERS-1:0]         request,
   input  logic                              update_lru,
   output logic [NUM_REQUESTERS-1:0]         grant_oh,
   output logic [$clog2(NUM_REQUESTERS)-1:0] grant_idx,
   output logic                              grant_valid
);

   localparam int IDX_WIDTH = $clog2(NUM_REQUESTERS);
   // MAX_BURST=1 never counts, but the counter still needs a legal width.
   localparam int CNT_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam bit MSB0      = (DIRECTION == "MSB0");

   logic [IDX_WIDTH-1:0]      ptr_q, ptr_d;
   logic                      lock_valid_q, lock_valid_d;
   logic [IDX_WIDTH-1:0]      lock_idx_q, lock_idx_d;
   logic [CNT_WIDTH-1:0]      burst_cnt_q, burst_cnt_d;

   logic [NUM_REQUESTERS-1:0] req_l;     // request in logical order
   logic [NUM_REQUESTERS-1:0] gnt_l;     // grant in logical order
   logic                      lock_hit;
   logic                      rr_found;
   logic [IDX_WIDTH-1:0]      rr_idx;
   logic [IDX_WIDTH-1:0]      cand_idx;
   int                        cand;
   int                        base_cnt;

   // Bit order only matters at the ports; everything inside works on logical indices.
   always_comb begin
      req_l    = '0;
      grant_oh = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (MSB0) begin
            req_l[i]                      = request[NUM_REQUESTERS-1-i];
            grant_oh[NUM_REQUESTERS-1-i]  = gnt_l[i];
         end else begin
            req_l[i]    = request[i];
            grant_oh[i] = gnt_l[i];
         end
      end
   end

   assign lock_hit = lock_valid_q & req_l[lock_idx_q];

   // Search ptr, ptr+1, ... wrapping modulo NUM_REQUESTERS (not modulo 2^IDX_WIDTH).
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NUM_REQUESTERS) begin
            cand = cand - NUM_REQUESTERS;
         end
         cand_idx = IDX_WIDTH'(cand);
         if (!rr_found && req_l[cand_idx]) begin
            rr_found = 1'b1;
            rr_idx   = cand_idx;
         end
      end
   end

   assign grant_valid = |request;
   assign grant_idx   = lock_hit ? lock_idx_q : rr_idx;
   assign gnt_l       = grant_valid ? (NUM_REQUESTERS'(1) << grant_idx) : '0;

   always_comb begin
      ptr_d        = ptr_q;
      lock_valid_d = lock_valid_q;
      lock_idx_d   = lock_idx_q;
      burst_cnt_d  = burst_cnt_q;
      // A grant that is not the held lock starts a fresh burst.
      base_cnt     = lock_hit ? int'(burst_cnt_q) : 0;
      if (update_lru && grant_valid) begin
         ptr_d = (int'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + IDX_WIDTH'(1);
         if (base_cnt + 1 < MAX_BURST) begin
            lock_valid_d = 1'b1;
            lock_idx_d   = grant_idx;
            burst_cnt_d  = CNT_WIDTH'(base_cnt + 1);
         end else begin
            lock_valid_d = 1'b0;
            burst_cnt_d  = '0;
         end
      end else if (lock_valid_q && !lock_hit) begin
         // Locked requester went away: drop the lock even without a consume.
         lock_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q        <= '0;
         lock_valid_q <= 1'b0;
         lock_idx_q   <= '0;
         burst_cnt_q  <= '0;
      end else begin
         ptr_q        <= ptr_d;
         lock_valid_q <= lock_valid_d;
         lock_idx_q   <= lock_idx_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed bench for burst_rr_arbiter: a 7-requester LSB0 instance with MAX_BURST=3,
// an MSB0 instance and a MAX_BURST=1 instance.
module tb_burst_rr_arbiter;

   localparam int N = 7;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] request, request_m, request_1;
   logic         update_lru, update_m, update_1;
   logic [N-1:0] grant_oh, grant_oh_m, grant_oh_1;
   logic [2:0]   grant_idx, grant_idx_m, grant_idx_1;
   logic         grant_valid, grant_valid_m, grant_valid_1;

   int checks = 0;
   int errors = 0;
   int exp_seq [7];

   always #5 clk = ~clk;

   burst_rr_arbiter #(.NUM_REQUESTERS(N), .DIRECTION("LSB0"), .MAX_BURST(3)) dut (
      .clk(clk), .reset(reset), .request(request), .update_lru(update_lru),
      .grant_oh(grant_oh), .grant_idx(grant_idx), .grant_valid(grant_valid)
   );

   burst_rr_arbiter #(.NUM_REQUESTERS(N), .DIRECTION("MSB0"), .MAX_BURST(3)) dut_m (
      .clk(clk), .reset(reset), .request(request_m), .update_lru(update_m),
      .grant_oh(grant_oh_m), .grant_idx(grant_idx_m), .grant_valid(grant_valid_m)
   );

   burst_rr_arbiter #(.NUM_REQUESTERS(N), .DIRECTION("LSB0"), .MAX_BURST(1)) dut_1 (
      .clk(clk), .reset(reset), .request(request_1), .update_lru(update_1),
      .grant_oh(grant_oh_1), .grant_idx(grant_idx_1), .grant_valid(grant_valid_1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      request    = '0;
      request_m  = '0;
      request_1  = '0;
      update_lru = 1'b0;
      update_m   = 1'b0;
      update_1   = 1'b0;
      #3;
      chk("rst_valid", 32'(grant_valid), 0);
      chk("rst_oh", 32'(grant_oh), 0);
      chk("rst_idx", 32'(grant_idx), 0);
      tick();
      reset = 1'b0;
      #1;

      // Idle with consume: nothing granted, state must not move.
      update_lru = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("idle_valid", 32'(grant_valid), 0);
         chk("idle_oh", 32'(grant_oh), 0);
         chk("idle_idx", 32'(grant_idx), 0);
         tick();
      end

      // Full load without consume: grant held.
      request    = 7'h7F;
      update_lru = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("hold_idx", 32'(grant_idx), 0);
         tick();
      end

      // Full-load rotation with bursts of 3.
      update_lru = 1'b1;
      for (int k = 0; k < 22; k++) begin
         #1;
         chk("rot_idx", 32'(grant_idx), 32'((k / 3) % 7));
         chk("rot_oh", 32'(grant_oh), 32'(1) << ((k / 3) % 7));
         chk("rot_valid", 32'(grant_valid), 1);
         tick();
      end
      update_lru = 1'b0;

      // MSB0 instance: logical index i lives on bit 6-i.
      request_m = 7'b1000000;
      #1;
      chk("msb0_oh_l0", 32'(grant_oh_m), 32'h40);
      chk("msb0_idx_l0", 32'(grant_idx_m), 0);
      request_m = 7'b0000001;
      #1;
      chk("msb0_oh_l6", 32'(grant_oh_m), 32'h01);
      chk("msb0_idx_l6", 32'(grant_idx_m), 6);
      request_m = 7'b0000110;
      #1;
      chk("msb0_oh_l4", 32'(grant_oh_m), 32'h04);
      chk("msb0_idx_l4", 32'(grant_idx_m), 4);
      request_m = 7'h7F;
      update_m  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("msb0_burst_idx", 32'(grant_idx_m), (k < 3) ? 0 : 1);
         chk("msb0_burst_oh", 32'(grant_oh_m), (k < 3) ? 32'h40 : 32'h20);
         tick();
      end
      update_m  = 1'b0;
      request_m = '0;

      // MAX_BURST=1: plain round robin.
      request_1 = 7'h7F;
      update_1  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("mb1_idx", 32'(grant_idx_1), 32'(k % 7));
         chk("mb1_oh", 32'(grant_oh_1), 32'(1) << (k % 7));
         tick();
      end
      update_1 = 1'b0;

      // Lock broken early.
      pulse_reset();
      request    = 7'h04;
      update_lru = 1'b1;
      #1;
      chk("brk_first", 32'(grant_idx), 2);
      tick();
      request    = 7'h7B;
      update_lru = 1'b0;
      #1;
      chk("brk_idx", 32'(grant_idx), 3);
      chk("brk_oh", 32'(grant_oh), 32'h08);
      tick();
      request = 7'h7F;
      #1;
      chk("brk_lock_clr", 32'(grant_idx), 3);

      // Non-power-of-two wrap from ptr=6.
      pulse_reset();
      request    = 7'h20;
      update_lru = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("wrap_pre", 32'(grant_idx), 5);
         tick();
      end
      request    = 7'h41;
      exp_seq    = '{6, 6, 6, 0, 0, 0, 6};
      for (int k = 0; k < 7; k++) begin
         #1;
         chk("wrap_idx", 32'(grant_idx), 32'(exp_seq[k]));
         tick();
      end

      // Reset mid-burst.
      pulse_reset();
      request    = 7'h10;
      update_lru = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("mid_pre", 32'(grant_idx), 4);
         tick();
      end
      request    = 7'h7F;
      update_lru = 1'b0;
      #1;
      chk("mid_locked", 32'(grant_idx), 4);
      reset = 1'b1;
      #1;
      chk("mid_async", 32'(grant_idx), 0);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_release", 32'(grant_idx), 0);
      update_lru = 1'b1;
      tick();
      #1;
      chk("mid_after", 32'(grant_idx), 0);
      update_lru = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
